timer8_ctrl: RTL
================

// Module: timer8_ctrl
// PURPOSE
//  Control FSM sitting directly upstream of the 8-bit loadable counter.
//  Drives counter load/enable/init, watches the counter value fed back and
//  raises a one-cycle tick at terminal count. Supports one-shot and
//  auto-reload modes, plus a hold (pause) input, to form a programmable
//  interval timer.
// PARAMETERS
//  WIDTH  8  width of period, cnt feedback and cnt_init
// PORTS
//  clk       in   1      system clock; all state updates on posedge clk
//  res       in   1      reset; asynchronous, active-high
//  start     in   1      level-sampled start request
//  stop      in   1      abort; highest priority after res
//  hold      in   1      pause counting while high (RUN only)
//  mode      in   1      0 = one-shot, 1 = auto-reload; latched at start
//  period    in   WIDTH  terminal count value; latched at start
//  cnt       in   WIDTH  counter output fed back
//  cnt_load  out  1      counter load select
//  cnt_en    out  1      counter enable
//  cnt_init  out  WIDTH  counter load value, constant 0
//  busy      out  1      high in LOAD or RUN
//  done      out  1      high in DONE (one-shot finished)
//  tick      out  1      registered one-cycle terminal-count pulse
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-high on res:
//    state=IDLE, per_q=0, mode_q=0, tick=0. All outputs read 0 while res
//    is high, including reset mid-operation.
//  - States: IDLE, LOAD, RUN, DONE. Outputs decode from state; tick is a flop.
//  - IDLE: cnt_en=0, cnt_load=0. On start=1 & stop=0: latch period->per_q
//    and mode->mode_q; next state LOAD.
//  - LOAD: cnt_load=1, cnt_en=1, so the counter takes 0 at the next edge.
//    Next state RUN (unless stop).
//  - RUN: match = (cnt == per_q). cnt_en = ~hold & ~match; cnt_load=0.
//    * match & ~hold: tick<=1; next LOAD if mode_q=1, else DONE.
//    * match & hold: stay in RUN, no tick; the counter is held at per_q.
//    * start is ignored in RUN. period/mode changes are ignored until the
//      next latch.
//  - DONE: counter is held (cnt_en=0), so cnt stays at per_q.
//    On start=1: relatch, then LOAD. Otherwise stay in DONE.
//  - stop=1 in any state: next state IDLE, tick<=0. stop wins over start
//    and over match in the same cycle.
//  - tick is high for exactly one cycle after each terminal-count edge.
//  - Latency: start sampled at edge E0 -> LOAD after E0, cnt=0 after E1,
//    cnt=k after E(k+1), tick and the state change after E(P+2).
//  - Auto-reload tick period (no hold) = P+2 cycles: 1 LOAD + (P+1) RUN.
//  - P=0 is legal: match occurs in the first RUN cycle.
//  - P=2^WIDTH-1: the counter never wraps, because en drops at match.
//  - Arithmetic is an unsigned WIDTH-bit compare only; no internal counter.
// TESTING
//  T1 one-shot P=3, start pulse at edge0 -> cnt_load high cycle1;
//     cnt 0,1,2,3 after edges 1..4; tick=1 and done=1 after edge5;
//     cnt stays 3.
//  T2 auto-reload P=0 -> tick every 2 cycles. busy stays 1 and done stays 0
//     for 10 ticks.
//  T3 P=5 with hold=1 for 3 cycles while cnt=5 -> no tick during hold;
//     tick the cycle after hold drops; cnt stays 5 throughout.
//  T4 stop with start in IDLE -> remains IDLE. stop in RUN at cnt=2 ->
//     IDLE next edge, cnt_en=0, no tick.
//  T5 period changed 3->9 mid-RUN -> tick still at cnt=3. A restart from
//     DONE uses 9.
//  T6 res pulsed asynchronously mid-RUN (not on a clock edge) -> busy, tick
//     and cnt_en go 0 immediately; FSM is in IDLE after release.

Source files
------------

// File: rtl/timer8_ctrl.sv
// timer8_ctrl: control FSM for an 8-bit loadable counter forming a
// programmable interval timer. It drives the counter's load, enable and
// init inputs, compares the fed-back count against the latched period,
// and pulses tick for one cycle at terminal count. It supports one-shot
// and auto-reload modes, a hold (pause) input, and a stop (abort) input.
module timer8_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] cnt,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_init,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] per_q;
  logic             mode_q;
  logic             latch;
  logic             tick_next;
  logic             match;

  // The counter always restarts from zero. The period is the terminal value.
  assign cnt_init = '0;

  // Terminal count: a pure unsigned compare of the counter against the latched period.
  assign match = (cnt == per_q);

  // State register, period/mode latches and the registered tick flop.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state  <= IDLE;
      per_q  <= '0;
      mode_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      if (latch) begin
        per_q  <= period;
        mode_q <= mode;
      end
    end
  end

  // Next-state logic. stop overrides start and match in every state.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    tick_next  = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            latch      = 1'b1;
            state_next = LOAD;
          end
        end
        LOAD: begin
          state_next = RUN;
        end
        RUN: begin
          // start is deliberately ignored here. A held match waits in RUN.
          if (match && !hold) begin
            tick_next  = 1'b1;
            state_next = mode_q ? LOAD : DONE;
          end
        end
        DONE: begin
          if (start) begin
            latch      = 1'b1;
            state_next = LOAD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode from the current state. The enable drops at match so the counter never wraps.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        cnt_load = 1'b1;
        cnt_en   = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        cnt_en = ~hold & ~match;
        busy   = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
